// File: rtl/rram_wv_ctrl.sv
// rtl/rram_wv_ctrl.sv - read / write-verify sequencer for the rram_1p3Mb macro; optional RRAM_CTRL_PULSE_CNT_EN adds pulse_cnt_o
module rram_wv_ctrl #(
  parameter int ADDR_BITS    = 17,
  parameter int WORD_SIZE    = 16,
  parameter int READ_REF_W   = 4,
  parameter int CLAMP_REF_W  = 4,
  parameter int READ_DAC_W   = 4,
  parameter int WL_DAC_W     = 4,
  parameter int BSL_DAC_W    = 4,
  parameter int SETUP_CYCLES = 4,
  parameter int PW_CYCLES    = 2,
  parameter int MAX_ATTEMPTS = 8,
  parameter int SA_TIMEOUT   = 16
) (
  input  logic                   mclk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_op_i,
  input  logic [ADDR_BITS-1:0]   cmd_addr_i,
  input  logic [WORD_SIZE-1:0]   cmd_data_i,
  output logic                   rsp_valid_o,
  output logic [WORD_SIZE-1:0]   rsp_data_o,
  output logic [1:0]             rsp_status_o,
  input  logic [READ_REF_W-1:0]  read_ref_cfg_i,
  input  logic [CLAMP_REF_W-1:0] clamp_ref_cfg_i,
  input  logic [READ_DAC_W-1:0]  read_dac_cfg_i,
  input  logic [WL_DAC_W-1:0]    wl_dac_rd_cfg_i,
  input  logic [WL_DAC_W-1:0]    wl_dac_wr_cfg_i,
  input  logic [BSL_DAC_W-1:0]   bsl_dac_set_cfg_i,
  input  logic [BSL_DAC_W-1:0]   bsl_dac_rst_cfg_i,
  output logic [ADDR_BITS-1:0]   rram_addr_o,
  output logic [WORD_SIZE-1:0]   di_o,
  output logic                   set_rst_o,
  output logic                   we_o,
  output logic                   aclk_o,
  output logic                   wl_en_o,
  output logic                   bl_en_o,
  output logic                   sl_en_o,
  output logic                   bleed_en_o,
  output logic                   read_dac_en_o,
  output logic                   wl_dac_en_o,
  output logic                   bsl_dac_en_o,
  output logic                   sa_en_o,
  output logic                   sa_clk_o,
  output logic [READ_REF_W-1:0]  read_ref_o,
  output logic [CLAMP_REF_W-1:0] clamp_ref_o,
  output logic [READ_DAC_W-1:0]  read_dac_config_o,
  output logic [WL_DAC_W-1:0]    wl_dac_config_o,
  output logic [BSL_DAC_W-1:0]   bsl_dac_config_o,
  input  logic [WORD_SIZE-1:0]   sa_do_i,
  input  logic                   sa_rdy_i,
  output logic                   man_o
`ifdef RRAM_CTRL_PULSE_CNT_EN
  ,
  output logic [15:0]            pulse_cnt_o
`endif
);

  localparam int TMAX_SP = (SETUP_CYCLES > PW_CYCLES) ? SETUP_CYCLES : PW_CYCLES;
  localparam int TMAX    = (TMAX_SP > SA_TIMEOUT) ? TMAX_SP : SA_TIMEOUT;
  localparam int TMR_W   = $clog2(TMAX + 1);
  localparam int ATT_W   = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SETUP, S_RD_SENSE, S_RD_WAIT, S_CHECK,
    S_WR_SETUP, S_WR_PULSE, S_WR_GAP, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [ATT_W-1:0]     att_q, att_d;
  logic                 op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] tgt_q, tgt_d;
  logic [WORD_SIZE-1:0] rd_q, rd_d;
  logic [WORD_SIZE-1:0] need_set_q, need_set_d;
  logic [WORD_SIZE-1:0] need_rst_q, need_rst_d;
  logic                 phase_set_q, phase_set_d;
  logic [1:0]           status_q, status_d;
  logic                 ready_q;
  logic [WORD_SIZE-1:0] set_mask, rst_mask;
  logic                 rd_phase, wr_phase;

  assign set_mask    = tgt_q & ~rd_q;
  assign rst_mask    = ~tgt_q & rd_q;
  assign cmd_ready_o = ready_q && (state_q == S_IDLE);

  always_ff @(posedge mclk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      att_q       <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      tgt_q       <= '0;
      rd_q        <= '0;
      need_set_q  <= '0;
      need_rst_q  <= '0;
      phase_set_q <= 1'b0;
      status_q    <= 2'd0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      att_q       <= att_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      tgt_q       <= tgt_d;
      rd_q        <= rd_d;
      need_set_q  <= need_set_d;
      need_rst_q  <= need_rst_d;
      phase_set_q <= phase_set_d;
      status_q    <= status_d;
      ready_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    att_d       = att_q;
    op_d        = op_q;
    addr_d      = addr_q;
    tgt_d       = tgt_q;
    rd_d        = rd_q;
    need_set_d  = need_set_q;
    need_rst_d  = need_rst_q;
    phase_set_d = phase_set_q;
    status_d    = status_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d    = cmd_op_i;
          addr_d  = cmd_addr_i;
          tgt_d   = cmd_data_i;
          att_d   = '0;
          state_d = S_RD_SETUP;
        end
      end
      S_RD_SETUP: if (tmr_q == TMR_W'(SETUP_CYCLES - 1)) state_d = S_RD_SENSE;
      S_RD_SENSE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (sa_rdy_i) begin
          rd_d    = sa_do_i;
          state_d = S_CHECK;
        end else if (tmr_q == TMR_W'(SA_TIMEOUT - 1)) begin
          status_d = 2'd2;
          state_d  = S_DONE;
        end
      end
      S_CHECK: begin
        need_set_d = set_mask;
        need_rst_d = rst_mask;
        if (!op_q || (set_mask == '0 && rst_mask == '0)) begin
          status_d = 2'd0;
          state_d  = S_DONE;
        end else if (att_q == ATT_W'(MAX_ATTEMPTS)) begin
          status_d = 2'd1;
          state_d  = S_DONE;
        end else begin
          att_d       = att_q + ATT_W'(1);
          phase_set_d = (set_mask != '0);
          state_d     = S_WR_SETUP;
        end
      end
      S_WR_SETUP: if (tmr_q == TMR_W'(SETUP_CYCLES - 1)) state_d = S_WR_PULSE;
      S_WR_PULSE: if (tmr_q == TMR_W'(PW_CYCLES - 1)) state_d = S_WR_GAP;
      S_WR_GAP: begin
        // A SET phase is chained straight into the RST phase of the same iteration.
        if (tmr_q == TMR_W'(SETUP_CYCLES - 1)) begin
          if (phase_set_q && need_rst_q != '0) begin
            phase_set_d = 1'b0;
            state_d     = S_WR_SETUP;
          end else begin
            state_d = S_RD_SETUP;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    tmr_d = (state_d != state_q || state_q == S_IDLE) ? '0 : tmr_q + TMR_W'(1);
  end

  assign rd_phase = (state_q == S_RD_SETUP) || (state_q == S_RD_SENSE) || (state_q == S_RD_WAIT);
  assign wr_phase = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) || (state_q == S_WR_GAP);

  always_comb begin
    di_o              = '0;
    set_rst_o         = 1'b0;
    we_o              = 1'b0;
    aclk_o            = 1'b0;
    wl_en_o           = 1'b0;
    bl_en_o           = 1'b0;
    sl_en_o           = 1'b0;
    bleed_en_o        = 1'b0;
    read_dac_en_o     = 1'b0;
    wl_dac_en_o       = 1'b0;
    bsl_dac_en_o      = 1'b0;
    sa_en_o           = 1'b0;
    sa_clk_o          = 1'b0;
    read_ref_o        = '0;
    clamp_ref_o       = '0;
    read_dac_config_o = '0;
    wl_dac_config_o   = '0;
    bsl_dac_config_o  = '0;
    if (rd_phase) begin
      wl_en_o           = 1'b1;
      bl_en_o           = 1'b1;
      sl_en_o           = 1'b1;
      bleed_en_o        = 1'b1;
      read_dac_en_o     = 1'b1;
      wl_dac_en_o       = 1'b1;
      bsl_dac_en_o      = 1'b1;
      set_rst_o         = 1'b1;
      di_o              = '1;
      wl_dac_config_o   = wl_dac_rd_cfg_i;
      read_ref_o        = read_ref_cfg_i;
      clamp_ref_o       = clamp_ref_cfg_i;
      read_dac_config_o = read_dac_cfg_i;
      sa_en_o           = (state_q != S_RD_SETUP);
      sa_clk_o          = (state_q == S_RD_SENSE);
    end
    if (wr_phase) begin
      wl_en_o          = 1'b1;
      bl_en_o          = 1'b1;
      sl_en_o          = 1'b1;
      wl_dac_en_o      = 1'b1;
      bsl_dac_en_o     = 1'b1;
      wl_dac_config_o  = wl_dac_wr_cfg_i;
      set_rst_o        = phase_set_q;
      di_o             = phase_set_q ? need_set_q : ~need_rst_q;
      bsl_dac_config_o = phase_set_q ? bsl_dac_set_cfg_i : bsl_dac_rst_cfg_i;
      we_o             = (state_q == S_WR_PULSE);
      aclk_o           = (state_q == S_WR_PULSE);
    end
  end

  assign rram_addr_o  = addr_q;
  assign rsp_valid_o  = (state_q == S_DONE);
  assign rsp_data_o   = rd_q;
  assign rsp_status_o = status_q;
  assign man_o        = 1'b0;

`ifdef RRAM_CTRL_PULSE_CNT_EN
  logic [15:0] pulse_cnt_q;

  always_ff @(posedge mclk_i) begin
    if (rst_i) begin
      pulse_cnt_q <= '0;
    end else if (state_q == S_WR_SETUP && state_d == S_WR_PULSE && pulse_cnt_q != 16'hFFFF) begin
      pulse_cnt_q <= pulse_cnt_q + 16'd1;
    end
  end

  assign pulse_cnt_o = pulse_cnt_q;
`endif

endmodule
